// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - enqueue-side handshake bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]        data;
  logic                        ok;
  logic                        full;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] level;

  modport master (output data, ok, input full, overflow, level);
  modport slave  (input data, ok, output full, overflow, level);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with configurable framing and a transmit FIFO
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          uart_tx,
  output logic          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_nxt;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic                 wr_en, pop, full_w, overflow_q;
  logic [DATA_BITS-1:0] head, shift_q;
  logic                 par_q;
  logic [31:0]          clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 bit_done, last_bit, last_stop, tx_nxt;

  assign full_w       = (count == LW'(FIFO_DEPTH));
  assign wr_en        = bus.ok && !full_w;
  assign head         = mem[rd_ptr];
  assign bus.full     = full_w;
  assign bus.level    = count;
  assign bus.overflow = overflow_q;
  assign busy         = (state != S_IDLE) || (count != '0);

  assign bit_done  = (clk_cnt == 32'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data;
  end

  // A rejected write is judged against full before any same-edge pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      overflow_q <= bus.ok && full_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      uart_tx <= tx_nxt;
      if (pop || bit_done || state == S_IDLE) clk_cnt <= '0;
      else                                    clk_cnt <= clk_cnt + 32'd1;
      if (state == S_DATA && bit_done) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        shift_q <= shift_q >> 1;
      end
      if (state == S_STOP && bit_done) stop_cnt <= last_stop ? 1'b0 : 1'b1;
      if (pop) begin
        shift_q <= head;
        par_q   <= (PARITY == 2) ? ^head : ~^head;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (count != '0) state_nxt = S_START;
      S_START:  if (bit_done) state_nxt = S_DATA;
      S_DATA:   if (bit_done && last_bit) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_nxt = S_STOP;
      S_STOP:   if (bit_done && last_stop) state_nxt = (count != '0) ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // uart_tx is registered; this computes the level it takes after the edge.
  always_comb begin
    tx_nxt = uart_tx;
    pop    = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (count != '0) begin
          pop    = 1'b1;
          tx_nxt = 1'b0;
        end
      end
      S_START:  if (bit_done) tx_nxt = shift_q[0];
      S_DATA: begin
        if (bit_done) begin
          if (last_bit) tx_nxt = (PARITY != 0) ? par_q : 1'b1;
          else          tx_nxt = shift_q[1];
        end
      end
      S_PARITY: if (bit_done) tx_nxt = 1'b1;
      S_STOP: begin
        if (bit_done && last_stop) begin
          if (count != '0) begin
            pop    = 1'b1;
            tx_nxt = 1'b0;
          end else begin
            tx_nxt = 1'b1;
          end
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed, table-driven bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  int         wsel = 0;
  logic       wok = 1'b0;
  logic [8:0] wdata = '0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_n ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_e ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_o ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_f ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if_7 ();

  logic tx_n, tx_e, tx_o, tx_f, tx_7;
  logic busy_n, busy_e, busy_o, busy_f, busy_7;

  assign if_n.ok = wok && (wsel == 0);
  assign if_e.ok = wok && (wsel == 1);
  assign if_o.ok = wok && (wsel == 2);
  assign if_f.ok = wok && (wsel == 3);
  assign if_7.ok = wok && (wsel == 4);
  assign if_n.data = wdata[7:0];
  assign if_e.data = wdata[7:0];
  assign if_o.data = wdata[7:0];
  assign if_f.data = wdata[7:0];
  assign if_7.data = wdata[6:0];

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_n (.clk(clk), .reset(reset), .bus(if_n), .uart_tx(tx_n), .busy(busy_n));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_e (.clk(clk), .reset(reset), .bus(if_e), .uart_tx(tx_e), .busy(busy_e));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_o (.clk(clk), .reset(reset), .bus(if_o), .uart_tx(tx_o), .busy(busy_o));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_f (.clk(clk), .reset(reset), .bus(if_f), .uart_tx(tx_f), .busy(busy_f));
  uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16))
    u_7 (.clk(clk), .reset(reset), .bus(if_7), .uart_tx(tx_7), .busy(busy_7));

  logic        tx_sel, busy_sel, full_sel, ovf_sel;
  logic [31:0] level_sel;

  always_comb begin
    tx_sel = 1'b1; busy_sel = 1'b0; full_sel = 1'b0; ovf_sel = 1'b0; level_sel = '0;
    case (wsel)
      0: begin tx_sel = tx_n; busy_sel = busy_n; full_sel = if_n.full; ovf_sel = if_n.overflow; level_sel = 32'(if_n.level); end
      1: begin tx_sel = tx_e; busy_sel = busy_e; full_sel = if_e.full; ovf_sel = if_e.overflow; level_sel = 32'(if_e.level); end
      2: begin tx_sel = tx_o; busy_sel = busy_o; full_sel = if_o.full; ovf_sel = if_o.overflow; level_sel = 32'(if_o.level); end
      3: begin tx_sel = tx_f; busy_sel = busy_f; full_sel = if_f.full; ovf_sel = if_f.overflow; level_sel = 32'(if_f.level); end
      default: begin tx_sel = tx_7; busy_sel = busy_7; full_sel = if_7.full; ovf_sel = if_7.overflow; level_sel = 32'(if_7.level); end
    endcase
  end

  // frame holds the expected serial bits, bit 0 = first bit on the line
  typedef struct {
    int          sel;
    int          cpb;
    int          nbits;
    int          nw;
    logic [8:0]  w0;
    logic [8:0]  w1;
    logic [23:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_entry(input int e);
    vec_t v;
    int   len;
    v     = vecs[e];
    len   = v.nbits * v.cpb;
    wsel  = v.sel;
    wdata = v.w0;
    wok   = 1'b1;
    @(negedge clk);
    if (v.nw == 2) begin
      wdata = v.w1;
      @(negedge clk);
    end
    wok = 1'b0;
    check($sformatf("v%0d_level_written", e), level_sel, 32'd1);
    if (v.nw == 1) @(negedge clk);
    check($sformatf("v%0d_level_popped", e), level_sel, 32'(v.nw - 1));
    for (int j = 0; j < len; j++) begin
      check($sformatf("v%0d_tx_c%0d", e, j), 32'(tx_sel), 32'(v.frame[j / v.cpb]));
      @(negedge clk);
    end
    check($sformatf("v%0d_idle_tx", e), 32'(tx_sel), 32'd1);
    check($sformatf("v%0d_idle_busy", e), 32'(busy_sel), 32'd0);
    check($sformatf("v%0d_idle_level", e), level_sel, 32'd0);
  endtask

  function automatic logic exp_burst(input int j);
    logic [7:0] w;
    int         f, b;
    if (j >= 200) return 1'b1;
    f = j / 40;
    b = (j % 40) / 4;
    w = 8'(f + 1);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return w[b-1];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lv_exp[6];
    lv_exp = '{1, 1, 2, 3, 4, 4};

    vecs[0] = '{0, 4, 10, 1, 9'h0A5, 9'h000, 24'b1101001010};
    vecs[1] = '{1, 4, 11, 1, 9'h007, 9'h000, 24'b11000001110};
    vecs[2] = '{2, 4, 11, 1, 9'h007, 9'h000, 24'b10000001110};
    vecs[3] = '{4, 3, 10, 1, 9'h041, 9'h000, 24'b1110000010};
    vecs[4] = '{0, 4, 20, 2, 9'h055, 9'h0AA, 24'b11010101001010101010};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      wsel = s;
      #1;
      check($sformatf("rst%0d_tx", s), 32'(tx_sel), 32'd1);
      check($sformatf("rst%0d_busy", s), 32'(busy_sel), 32'd0);
      check($sformatf("rst%0d_level", s), level_sel, 32'd0);
      check($sformatf("rst%0d_full", s), 32'(full_sel), 32'd0);
      check($sformatf("rst%0d_ovf", s), 32'(ovf_sel), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 5; e++) run_entry(e);

    // six back-to-back writes into a depth-4 FIFO; only the first word is popped
    wsel = 3;
    wok  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 9'(i + 1);
      @(negedge clk);
      check($sformatf("burst_level_%0d", i), level_sel, 32'(lv_exp[i]));
      check($sformatf("burst_full_%0d", i), 32'(full_sel), 32'(i >= 4));
      check($sformatf("burst_ovf_%0d", i), 32'(ovf_sel), 32'(i == 5));
    end
    wok = 1'b0;
    @(negedge clk);
    check("burst_ovf_end", 32'(ovf_sel), 32'd0);
    for (int j = 5; j < 210; j++) begin
      check($sformatf("burst_tx_c%0d", j), 32'(tx_sel), 32'(exp_burst(j)));
      @(negedge clk);
    end
    check("burst_idle_busy", 32'(busy_sel), 32'd0);
    check("burst_idle_level", level_sel, 32'd0);

    wsel = 0;
    wok  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = 9'(i * 17);
      @(negedge clk);
    end
    wok = 1'b0;
    check("mid_level_queued", level_sel, 32'd3);
    repeat (4) @(negedge clk);
    check("mid_tx_data_low", 32'(tx_sel), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_sel), 32'd1);
    check("mid_rst_level", level_sel, 32'd0);
    check("mid_rst_busy", 32'(busy_sel), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet_c%0d", j), {30'd0, tx_sel, busy_sel}, 32'd2);
    end
    run_entry(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
